// File: rtl/bot_io_regs_pkg.sv
// Shared port-address map and reset constants for the Rojobot PicoBlaze I/O block.
// The same numbering is used by the PicoBlaze program build.
package bot_io_regs_pkg;

   localparam logic [4:0] PA_BTNS      = 5'h00;
   localparam logic [4:0] PA_SW_LO     = 5'h01;
   localparam logic [4:0] PA_LED_LO    = 5'h02;
   localparam logic [4:0] PA_DIG3      = 5'h03;
   localparam logic [4:0] PA_DIG2      = 5'h04;
   localparam logic [4:0] PA_DIG1      = 5'h05;
   localparam logic [4:0] PA_DIG0      = 5'h06;
   localparam logic [4:0] PA_DP_LO     = 5'h07;
   localparam logic [4:0] PA_RSVD_LO   = 5'h08;
   localparam logic [4:0] PA_MOT       = 5'h09;
   localparam logic [4:0] PA_LOCX      = 5'h0A;
   localparam logic [4:0] PA_LOCY      = 5'h0B;
   localparam logic [4:0] PA_BOTINFO   = 5'h0C;
   localparam logic [4:0] PA_SENSORS   = 5'h0D;
   localparam logic [4:0] PA_LMDIST    = 5'h0E;
   localparam logic [4:0] PA_RMDIST    = 5'h0F;
   localparam logic [4:0] PA_BTNS_ALT  = 5'h10;
   localparam logic [4:0] PA_SW_HI     = 5'h11;
   localparam logic [4:0] PA_LED_HI    = 5'h12;
   localparam logic [4:0] PA_DIG7      = 5'h13;
   localparam logic [4:0] PA_DIG6      = 5'h14;
   localparam logic [4:0] PA_DIG5      = 5'h15;
   localparam logic [4:0] PA_DIG4      = 5'h16;
   localparam logic [4:0] PA_DP_HI     = 5'h17;
   localparam logic [4:0] PA_RSVD_HI   = 5'h18;
   localparam logic [4:0] PA_MOT_ALT   = 5'h19;
   localparam logic [4:0] PA_LOCX_ALT  = 5'h1A;
   localparam logic [4:0] PA_LOCY_ALT  = 5'h1B;
   localparam logic [4:0] PA_BOTINFO_ALT = 5'h1C;
   localparam logic [4:0] PA_SENSORS_ALT = 5'h1D;
   localparam logic [4:0] PA_LMDIST_ALT  = 5'h1E;
   localparam logic [4:0] PA_RMDIST_ALT  = 5'h1F;

   localparam logic [4:0] DIG_RST = 5'h1F;

   localparam int NUM_DIG  = 8;
   localparam int NUM_SNAP = 6;

endpackage

// File: rtl/bot_io_regs_intr.sv
// Interrupt request latch: rising edge of upd_sysregs sets, interrupt_ack clears,
// set wins over a coincident ack.
module bot_intr_latch (
   input  logic clk,
   input  logic rst,
   input  logic upd,
   input  logic ack,
   output logic intr
);

   logic prev_q, prev_d;
   logic intr_q, intr_d;
   logic rise;

   always_comb begin
      rise   = upd & ~prev_q;
      prev_d = upd;
      intr_d = intr_q;
      if (rise)
         intr_d = 1'b1;
      else if (ack)
         intr_d = 1'b0;
   end

   // The edge detector keeps tracking upd during reset so a level held
   // across reset release is not mistaken for a new edge.
   always_ff @(posedge clk) begin
      prev_q <= prev_d;
      if (rst)
         intr_q <= 1'b0;
      else
         intr_q <= intr_d;
   end

   assign intr = intr_q;

endmodule

// File: rtl/bot_io_regs.sv
// PicoBlaze I/O register file for the Rojobot: output registers, bot status
// snapshots, registered read mux and the interrupt request.
module bot_io_regs #(
   parameter logic [4:0] DIG_RST     = bot_io_regs_pkg::DIG_RST,
   parameter logic [7:0] UNMAPPED_RD = 8'h00
) (
   input  logic        sysclk,
   input  logic        sysreset,
   input  logic [7:0]  port_id,
   input  logic        write_strobe,
   input  logic        read_strobe,
   input  logic [7:0]  out_port,
   output logic [7:0]  in_port,
   output logic        interrupt,
   input  logic        interrupt_ack,
   input  logic [5:0]  db_btns,
   input  logic [15:0] db_sw,
   output logic [15:0] leds,
   output logic [7:0]  decpts,
   output logic [7:0]  motctl,
   output logic [4:0]  dig0,
   output logic [4:0]  dig1,
   output logic [4:0]  dig2,
   output logic [4:0]  dig3,
   output logic [4:0]  dig4,
   output logic [4:0]  dig5,
   output logic [4:0]  dig6,
   output logic [4:0]  dig7,
   input  logic [7:0]  locx,
   input  logic [7:0]  locy,
   input  logic [7:0]  botinfo,
   input  logic [7:0]  sensors,
   input  logic [7:0]  lmdist,
   input  logic [7:0]  rmdist,
   input  logic        upd_sysregs
);

   import bot_io_regs_pkg::*;

   logic [15:0] leds_q, leds_d;
   logic [7:0]  decpts_q, decpts_d;
   logic [7:0]  motctl_q, motctl_d;
   logic [4:0]  dig_q [NUM_DIG];
   logic [4:0]  dig_d [NUM_DIG];
   logic [7:0]  snap_q [NUM_SNAP];
   logic [7:0]  snap_d [NUM_SNAP];
   logic [7:0]  in_port_q, in_port_d;
   logic        mapped;
   logic [4:0]  addr;
   logic        unused_rd;

   assign unused_rd = read_strobe;
   assign mapped    = (port_id[7:5] == 3'b000);
   assign addr      = port_id[4:0];

   always_comb begin
      leds_d   = leds_q;
      decpts_d = decpts_q;
      motctl_d = motctl_q;
      dig_d    = dig_q;
      snap_d   = snap_q;
      if (write_strobe && mapped) begin
         case (addr)
            PA_LED_LO:              leds_d[7:0]   = out_port;
            PA_LED_HI:              leds_d[15:8]  = out_port;
            PA_DIG0:                dig_d[0]      = out_port[4:0];
            PA_DIG1:                dig_d[1]      = out_port[4:0];
            PA_DIG2:                dig_d[2]      = out_port[4:0];
            PA_DIG3:                dig_d[3]      = out_port[4:0];
            PA_DIG4:                dig_d[4]      = out_port[4:0];
            PA_DIG5:                dig_d[5]      = out_port[4:0];
            PA_DIG6:                dig_d[6]      = out_port[4:0];
            PA_DIG7:                dig_d[7]      = out_port[4:0];
            PA_DP_LO:               decpts_d[3:0] = out_port[3:0];
            PA_DP_HI:               decpts_d[7:4] = out_port[3:0];
            PA_MOT, PA_MOT_ALT:     motctl_d      = out_port;
            default: ;
         endcase
      end
      if (upd_sysregs)
         snap_d = '{locx, locy, botinfo, sensors, lmdist, rmdist};
   end

   // Reads use the current (pre-capture, pre-write) register values.
   always_comb begin
      in_port_d = UNMAPPED_RD;
      if (mapped) begin
         case (addr)
            PA_BTNS, PA_BTNS_ALT:        in_port_d = {2'b00, db_btns};
            PA_SW_LO:                    in_port_d = db_sw[7:0];
            PA_SW_HI:                    in_port_d = db_sw[15:8];
            PA_LED_LO:                   in_port_d = leds_q[7:0];
            PA_LED_HI:                   in_port_d = leds_q[15:8];
            PA_DIG0:                     in_port_d = {3'b000, dig_q[0]};
            PA_DIG1:                     in_port_d = {3'b000, dig_q[1]};
            PA_DIG2:                     in_port_d = {3'b000, dig_q[2]};
            PA_DIG3:                     in_port_d = {3'b000, dig_q[3]};
            PA_DIG4:                     in_port_d = {3'b000, dig_q[4]};
            PA_DIG5:                     in_port_d = {3'b000, dig_q[5]};
            PA_DIG6:                     in_port_d = {3'b000, dig_q[6]};
            PA_DIG7:                     in_port_d = {3'b000, dig_q[7]};
            PA_DP_LO:                    in_port_d = {4'h0, decpts_q[3:0]};
            PA_DP_HI:                    in_port_d = {4'h0, decpts_q[7:4]};
            PA_MOT, PA_MOT_ALT:          in_port_d = motctl_q;
            PA_LOCX, PA_LOCX_ALT:        in_port_d = snap_q[0];
            PA_LOCY, PA_LOCY_ALT:        in_port_d = snap_q[1];
            PA_BOTINFO, PA_BOTINFO_ALT:  in_port_d = snap_q[2];
            PA_SENSORS, PA_SENSORS_ALT:  in_port_d = snap_q[3];
            PA_LMDIST, PA_LMDIST_ALT:    in_port_d = snap_q[4];
            PA_RMDIST, PA_RMDIST_ALT:    in_port_d = snap_q[5];
            default:                     in_port_d = UNMAPPED_RD;
         endcase
      end
   end

   always_ff @(posedge sysclk) begin
      if (sysreset) begin
         leds_q    <= '0;
         decpts_q  <= '0;
         motctl_q  <= '0;
         in_port_q <= '0;
         for (int i = 0; i < NUM_DIG; i++)  dig_q[i]  <= DIG_RST;
         for (int i = 0; i < NUM_SNAP; i++) snap_q[i] <= '0;
      end else begin
         leds_q    <= leds_d;
         decpts_q  <= decpts_d;
         motctl_q  <= motctl_d;
         in_port_q <= in_port_d;
         dig_q     <= dig_d;
         snap_q    <= snap_d;
      end
   end

   bot_intr_latch u_intr (
      .clk  (sysclk),
      .rst  (sysreset),
      .upd  (upd_sysregs),
      .ack  (interrupt_ack),
      .intr (interrupt)
   );

   assign in_port = in_port_q;
   assign leds    = leds_q;
   assign decpts  = decpts_q;
   assign motctl  = motctl_q;
   assign dig0    = dig_q[0];
   assign dig1    = dig_q[1];
   assign dig2    = dig_q[2];
   assign dig3    = dig_q[3];
   assign dig4    = dig_q[4];
   assign dig5    = dig_q[5];
   assign dig6    = dig_q[6];
   assign dig7    = dig_q[7];

endmodule

// File: tb/tb_bot_io_regs.sv
// Self-checking bench for bot_io_regs: directed scenarios plus a randomized run
// against an address-map reference model.
module tb_bot_io_regs;

   logic        sysclk, sysreset;
   logic [7:0]  port_id, out_port;
   logic        write_strobe, read_strobe, interrupt_ack, upd_sysregs;
   logic [7:0]  in_port, decpts, motctl;
   logic        interrupt;
   logic [5:0]  db_btns;
   logic [15:0] db_sw, leds;
   logic [4:0]  dig0, dig1, dig2, dig3, dig4, dig5, dig6, dig7;
   logic [7:0]  locx, locy, botinfo, sensors, lmdist, rmdist;
   logic [4:0]  dut_dig [8];

   int n_chk = 0;
   int n_pass = 0;

   // reference model state
   logic [15:0] m_leds;
   logic [7:0]  m_dec, m_mot;
   logic [4:0]  m_dig [8];
   logic [7:0]  m_snap [6];
   logic        m_intr, m_prev;
   logic [7:0]  exp_in;

   bot_io_regs dut (
      .sysclk(sysclk), .sysreset(sysreset), .port_id(port_id),
      .write_strobe(write_strobe), .read_strobe(read_strobe), .out_port(out_port),
      .in_port(in_port), .interrupt(interrupt), .interrupt_ack(interrupt_ack),
      .db_btns(db_btns), .db_sw(db_sw), .leds(leds), .decpts(decpts), .motctl(motctl),
      .dig0(dig0), .dig1(dig1), .dig2(dig2), .dig3(dig3),
      .dig4(dig4), .dig5(dig5), .dig6(dig6), .dig7(dig7),
      .locx(locx), .locy(locy), .botinfo(botinfo), .sensors(sensors),
      .lmdist(lmdist), .rmdist(rmdist), .upd_sysregs(upd_sysregs)
   );

   assign dut_dig = '{dig0, dig1, dig2, dig3, dig4, dig5, dig6, dig7};

   initial sysclk = 1'b0;
   always #5 sysclk = ~sysclk;

   function automatic logic [7:0] model_read(input logic [7:0] a);
      int lo, hi;
      lo = int'(a[3:0]);
      hi = int'(a[4]);
      if (a[7:5] != 3'b000) return 8'h00;
      if (lo == 0) return {2'b00, db_btns};
      if (lo == 1) return hi ? db_sw[15:8] : db_sw[7:0];
      if (lo == 2) return hi ? m_leds[15:8] : m_leds[7:0];
      if (lo >= 3 && lo <= 6) return {3'b000, m_dig[hi*4 + 6 - lo]};
      if (lo == 7) return {4'h0, hi ? m_dec[7:4] : m_dec[3:0]};
      if (lo == 8) return 8'h00;
      if (lo == 9) return m_mot;
      return m_snap[lo - 10];
   endfunction

   // Advance one clock: predict the effect of the inputs now applied, then step.
   task automatic cycle();
      int lo, hi;
      logic rise;
      lo = int'(port_id[3:0]);
      hi = int'(port_id[4]);
      exp_in = model_read(port_id);
      if (sysreset) begin
         m_leds = '0; m_dec = '0; m_mot = '0; m_intr = 1'b0; exp_in = 8'h00;
         for (int i = 0; i < 8; i++) m_dig[i] = 5'h1F;
         for (int i = 0; i < 6; i++) m_snap[i] = 8'h00;
      end else begin
         if (write_strobe && port_id[7:5] == 3'b000) begin
            if (lo == 2) begin
               if (hi == 1) m_leds[15:8] = out_port; else m_leds[7:0] = out_port;
            end
            if (lo >= 3 && lo <= 6) m_dig[hi*4 + 6 - lo] = out_port[4:0];
            if (lo == 7) begin
               if (hi == 1) m_dec[7:4] = out_port[3:0]; else m_dec[3:0] = out_port[3:0];
            end
            if (lo == 9) m_mot = out_port;
         end
         if (upd_sysregs) m_snap = '{locx, locy, botinfo, sensors, lmdist, rmdist};
         rise = upd_sysregs && !m_prev;
         if (rise) m_intr = 1'b1;
         else if (interrupt_ack) m_intr = 1'b0;
      end
      m_prev = upd_sysregs;
      @(posedge sysclk);
      #1;
   endtask

   task automatic idle_inputs();
      write_strobe = 0; read_strobe = 0; interrupt_ack = 0;
      port_id = 8'h00; out_port = 8'h00;
   endtask

   task automatic test_reset();
      sysreset = 1; idle_inputs(); upd_sysregs = 0;
      db_btns = '0; db_sw = '0;
      locx = 0; locy = 0; botinfo = 0; sensors = 0; lmdist = 0; rmdist = 0;
      repeat (3) cycle();
      sysreset = 0;
      n_chk++; if (leds !== 16'h0) $display("FAIL rst_leds got=%h exp=0", leds); else n_pass++;
      n_chk++; if (decpts !== 8'h0) $display("FAIL rst_decpts got=%h exp=0", decpts); else n_pass++;
      n_chk++; if (motctl !== 8'h0) $display("FAIL rst_motctl got=%h exp=0", motctl); else n_pass++;
      n_chk++; if (in_port !== 8'h0) $display("FAIL rst_in_port got=%h exp=0", in_port); else n_pass++;
      n_chk++; if (interrupt !== 1'b0) $display("FAIL rst_interrupt got=%b exp=0", interrupt); else n_pass++;
      for (int i = 0; i < 8; i++) begin
         n_chk++;
         if (dut_dig[i] !== 5'h1F) $display("FAIL rst_dig%0d got=%h exp=1f", i, dut_dig[i]);
         else n_pass++;
      end
   endtask

   task automatic test_leds();
      port_id = 8'h02; out_port = 8'hA5; write_strobe = 1; cycle();
      n_chk++; if (leds !== 16'h00A5) $display("FAIL leds_lo got=%h exp=00a5", leds); else n_pass++;
      port_id = 8'h12; out_port = 8'h3C; cycle();
      n_chk++; if (leds !== 16'h3CA5) $display("FAIL leds_hi got=%h exp=3ca5", leds); else n_pass++;
      write_strobe = 0; port_id = 8'h02; cycle();
      n_chk++; if (in_port !== 8'hA5) $display("FAIL rd_led_lo got=%h exp=a5", in_port); else n_pass++;
      port_id = 8'h12; cycle();
      n_chk++; if (in_port !== 8'h3C) $display("FAIL rd_led_hi got=%h exp=3c", in_port); else n_pass++;
   endtask

   task automatic test_ignored_writes();
      port_id = 8'h0A; out_port = 8'hFF; write_strobe = 1; cycle();
      port_id = 8'h08; cycle();
      port_id = 8'h2A; cycle();
      write_strobe = 0; port_id = 8'h0A; cycle();
      n_chk++; if (in_port !== 8'h00) $display("FAIL rd_locx_after_wr got=%h exp=00", in_port); else n_pass++;
      port_id = 8'h08; cycle();
      n_chk++; if (in_port !== 8'h00) $display("FAIL rd_rsvd08 got=%h exp=00", in_port); else n_pass++;
      port_id = 8'h2A; cycle();
      n_chk++; if (in_port !== 8'h00) $display("FAIL rd_unmapped2a got=%h exp=00", in_port); else n_pass++;
      n_chk++; if (leds !== 16'h3CA5) $display("FAIL leds_after_bad_wr got=%h exp=3ca5", leds); else n_pass++;
   endtask

   task automatic test_snapshot();
      locx = 8'h10; upd_sysregs = 1; port_id = 8'h0A; cycle();
      n_chk++; if (in_port !== 8'h00) $display("FAIL rd_pre_capture got=%h exp=00", in_port); else n_pass++;
      locx = 8'h20; upd_sysregs = 0; cycle();
      cycle();
      n_chk++; if (in_port !== 8'h10) $display("FAIL rd_locx got=%h exp=10", in_port); else n_pass++;
      port_id = 8'h1A; cycle();
      n_chk++; if (in_port !== 8'h10) $display("FAIL rd_locx_alias got=%h exp=10", in_port); else n_pass++;
      interrupt_ack = 1; cycle(); interrupt_ack = 0;
      n_chk++; if (interrupt !== 1'b0) $display("FAIL snap_ack got=%b exp=0", interrupt); else n_pass++;
   endtask

   task automatic test_interrupt();
      int highs = 0;
      upd_sysregs = 1;
      for (int i = 0; i < 5; i++) begin
         cycle();
         if (interrupt === 1'b1) highs++;
      end
      upd_sysregs = 0; cycle();
      n_chk++; if (highs != 5 || interrupt !== 1'b1) $display("FAIL intr_set highs=%0d intr=%b exp=5,1", highs, interrupt); else n_pass++;
      interrupt_ack = 1; cycle(); interrupt_ack = 0;
      n_chk++; if (interrupt !== 1'b0) $display("FAIL intr_ack got=%b exp=0", interrupt); else n_pass++;
      repeat (3) cycle();
      n_chk++; if (interrupt !== 1'b0) $display("FAIL intr_single got=%b exp=0", interrupt); else n_pass++;
      upd_sysregs = 1; cycle(); upd_sysregs = 0; cycle();
      upd_sysregs = 1; interrupt_ack = 1; cycle();
      upd_sysregs = 0; interrupt_ack = 0;
      n_chk++; if (interrupt !== 1'b1) $display("FAIL intr_set_wins got=%b exp=1", interrupt); else n_pass++;
   endtask

   task automatic test_reset_priority();
      n_chk++; if (interrupt !== 1'b1) $display("FAIL pre_rst_intr got=%b exp=1", interrupt); else n_pass++;
      port_id = 8'h05; out_port = 8'h0A; write_strobe = 1; upd_sysregs = 1; sysreset = 1;
      cycle();
      sysreset = 0; write_strobe = 0;
      n_chk++; if (dig1 !== 5'h1F) $display("FAIL rstpri_dig1 got=%h exp=1f", dig1); else n_pass++;
      n_chk++; if (leds !== 16'h0) $display("FAIL rstpri_leds got=%h exp=0", leds); else n_pass++;
      n_chk++; if (interrupt !== 1'b0) $display("FAIL rstpri_intr got=%b exp=0", interrupt); else n_pass++;
      repeat (4) begin
         cycle();
         n_chk++; if (interrupt !== 1'b0) $display("FAIL release_intr got=%b exp=0", interrupt); else n_pass++;
      end
      upd_sysregs = 0; cycle();
   endtask

   task automatic test_switch_reads();
      db_sw = 16'hBEEF; db_btns = 6'b101010;
      port_id = 8'h01; cycle();
      n_chk++; if (in_port !== 8'hEF) $display("FAIL rd_sw_lo got=%h exp=ef", in_port); else n_pass++;
      port_id = 8'h11; cycle();
      n_chk++; if (in_port !== 8'hBE) $display("FAIL rd_sw_hi got=%h exp=be", in_port); else n_pass++;
      port_id = 8'h00; cycle();
      n_chk++; if (in_port !== 8'h2A) $display("FAIL rd_btns got=%h exp=2a", in_port); else n_pass++;
      port_id = 8'h10; cycle();
      n_chk++; if (in_port !== 8'h2A) $display("FAIL rd_btns_alias got=%h exp=2a", in_port); else n_pass++;
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         port_id       = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 31));
         out_port      = 8'($urandom);
         write_strobe  = ($urandom_range(0, 1) == 1);
         read_strobe   = ($urandom_range(0, 1) == 1);
         upd_sysregs   = ($urandom_range(0, 4) == 0);
         interrupt_ack = ($urandom_range(0, 5) == 0);
         sysreset      = ($urandom_range(0, 99) == 0);
         {locx, locy, botinfo} = 24'($urandom);
         {sensors, lmdist, rmdist} = 24'($urandom);
         if ($urandom_range(0, 9) == 0) begin
            db_sw = 16'($urandom); db_btns = 6'($urandom);
         end
         cycle();
         n_chk++; if (in_port !== exp_in) $display("FAIL rnd_in_port n=%0d got=%h exp=%h", n, in_port, exp_in); else n_pass++;
         n_chk++; if (leds !== m_leds) $display("FAIL rnd_leds n=%0d got=%h exp=%h", n, leds, m_leds); else n_pass++;
         n_chk++; if (decpts !== m_dec) $display("FAIL rnd_decpts n=%0d got=%h exp=%h", n, decpts, m_dec); else n_pass++;
         n_chk++; if (motctl !== m_mot) $display("FAIL rnd_motctl n=%0d got=%h exp=%h", n, motctl, m_mot); else n_pass++;
         n_chk++; if (interrupt !== m_intr) $display("FAIL rnd_intr n=%0d got=%b exp=%b", n, interrupt, m_intr); else n_pass++;
         for (int i = 0; i < 8; i++) begin
            n_chk++;
            if (dut_dig[i] !== m_dig[i]) $display("FAIL rnd_dig%0d n=%0d got=%h exp=%h", i, n, dut_dig[i], m_dig[i]);
            else n_pass++;
         end
      end
      sysreset = 0;
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_leds();
      test_ignored_writes();
      test_snapshot();
      test_interrupt();
      test_reset_priority();
      test_switch_reads();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
